tt_um_count_checker: RTL and testbench
======================================

Name: tt_um_count_checker

Overview:
Receive-side companion to the team's 8-bit free-running counter tile. The block samples a byte stream on ui_in and checks that it is an incrementing mod-256 count, with holds allowed. It acquires and loses lock through a small FSM and keeps a saturating error count. Status and error count are reported on the TinyTapeout user pins, so the block can be wired directly to a counter tile's uo_out for loopback test.

Parameters:
LOCK_CNT, 4, consecutive matching increments needed in ACQ to declare lock (1..15)
LOSS_CNT, 3, consecutive mismatches in LOCKED that drop lock back to ACQ (1..15)

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
ena  input  1  tile enable; when low, all state holds and no sample is taken
ui_in  input  8  sampled counter byte
uio_in  input  8  [0] err_sel (0: low error byte, 1: high error byte); [1] clr_err (synchronous clear); [7:2] ignored
uo_out  output  8  selected byte of err_cnt
uio_out  output  8  [1:0]=0; [2] locked; [3] err_sticky; [4] wrap_seen; [5]=0; [7:6] state code
uio_oe  output  8  constant 8'b1111_1100, including during reset

Behaviour:
- Reset (clk edge with rst_n=0):
  - state=HUNT; prev=0; match_cnt=0; miss_cnt=0; err_cnt=0; err_sticky=0; wrap_seen=0.
  - uo_out=0; uio_out=0.
- A sample is consumed on every clk edge with rst_n=1 and ena=1. With ena=0, every register holds.
- Sample classification, relative to prev:
  - MATCH: ui_in == prev+1 mod 256. 255->0 counts as MATCH.
  - STALL: ui_in == prev.
  - MISMATCH: anything else.
- prev <= ui_in on every consumed sample, whatever the class (resynchronising follower).
- State codes: HUNT=00, ACQ=01, LOCKED=10. Code 11 is unused; if reached, return to HUNT on the next edge.
- HUNT: first consumed sample loads prev, no classification; -> ACQ, match_cnt=0.
- ACQ:
  - MATCH: match_cnt+1; if the new value equals LOCK_CNT -> LOCKED, match_cnt=0, miss_cnt=0.
  - MISMATCH: match_cnt=0.
  - STALL: no change.
  - No error counting in ACQ.
- LOCKED:
  - MATCH: miss_cnt=0.
  - STALL: no change.
  - MISMATCH: err_cnt += 1, saturating at 16'hFFFF; err_sticky=1; miss_cnt+1. If the new miss_cnt equals LOSS_CNT -> ACQ, match_cnt=0, miss_cnt=0. The mismatch that drops lock is still counted.
- wrap_seen: registered one-cycle pulse. High the cycle after a 255->0 MATCH is consumed in LOCKED; otherwise 0.
- locked = (state==LOCKED), registered.
- clr_err (uio_in[1]=1, rst_n=1):
  - Clears err_cnt and err_sticky on that edge, regardless of ena.
  - Wins over a simultaneous increment.
  - Does not affect the FSM, prev or the other counters.
- uo_out = err_sel ? err_cnt[15:8] : err_cnt[7:0]. This is a combinational mux of a registered value, so err_sel takes effect the same cycle.
- Latency: a sample present before edge N is reflected in status and count after edge N.
- Lock timing: from reset release with ena=1 and a clean count, locked=1 after edge 1+LOCK_CNT.
- Reset mid-operation: immediate return to the reset state; any lock is discarded.

Test Plan:
- Reset, then ena=1, ui_in=0,1,2,... one per cycle -> state HUNT->ACQ after edge 1, locked=1 after edge 5 (LOCK_CNT=4), uo_out=0, err_sticky=0.
- Locked at 253, feed 254,255,0,1 -> no errors; wrap_seen=1 for exactly the one cycle after 0 is consumed; locked stays 1.
- Locked at 10, feed 11,11,11,12, plus ena=0 for 3 cycles with ui_in=99 -> all STALL/hold; err_cnt=0; locked=1.
- Locked at 20, feed 50 then 51 -> err_cnt=1, err_sticky=1, miss_cnt reset by 51, still locked. Then feed 7,3,9 -> err_cnt=4, state ACQ (code 01) after the third mismatch. Then 10,11,12,13 -> relocked.
- Force err_cnt to 16'hFFFF with 65535+ mismatches, holding lock by interleaving matches -> err_cnt saturates. uio_in[0]=1 -> uo_out=FF. Pulse clr_err on the same edge as a mismatch -> err_cnt=0, err_sticky=0.
- Reset asserted while LOCKED with err_cnt=5 -> next cycle uo_out=0, uio_out=0, uio_oe=FC, state HUNT.

Source files
------------

// File: rtl/tt_um_count_checker.sv
// tt_um_count_checker: receive-side checker for an 8-bit free-running counter.
// Follows the incoming byte stream, acquires lock after a run of clean
// increments, counts mismatches while locked (saturating 16-bit) and reports
// status and the selected error byte on the TinyTapeout user pins.
module tt_um_count_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    ACQ    = 2'b01,
    LOCKED = 2'b10,
    BAD    = 2'b11
  } state_t;

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_TGT = 4'(LOSS_CNT);

  state_t      state;
  state_t      state_next;
  logic [7:0]  prev;
  logic [3:0]  match_cnt;
  logic [3:0]  miss_cnt;
  logic [15:0] err_cnt;
  logic        err_sticky;
  logic        wrap_seen;
  logic        locked;

  logic        err_sel;
  logic        clr_err;
  logic [7:0]  prev_inc;
  logic        is_match;
  logic        is_stall;
  logic        is_miss;
  logic [3:0]  match_inc;
  logic [3:0]  miss_inc;
  logic        lock_hit;
  logic        loss_hit;
  logic        unused_uio;

  assign err_sel    = uio_in[0];
  assign clr_err    = uio_in[1];
  assign unused_uio = ^uio_in[7:2];

  // Sample classification against the previously consumed byte; 255->0 is a
  // match because the increment wraps in 8 bits.
  assign prev_inc  = prev + 8'd1;
  assign is_match  = (ui_in == prev_inc);
  assign is_stall  = (ui_in == prev);
  assign is_miss   = !is_match && !is_stall;
  assign match_inc = match_cnt + 4'd1;
  assign miss_inc  = miss_cnt + 4'd1;
  assign lock_hit  = (state == ACQ) && is_match && (match_inc == LOCK_TGT);
  assign loss_hit  = (state == LOCKED) && is_miss && (miss_inc == LOSS_TGT);

  // State register: only advances on consumed samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= HUNT;
    end else if (ena) begin
      state <= state_next;
    end
  end

  // Next-state logic: hunt loads the follower, acquire waits for a clean
  // run, locked falls back after a run of mismatches.
  always_comb begin
    state_next = state;
    case (state)
      HUNT:    state_next = ACQ;
      ACQ:     if (lock_hit) state_next = LOCKED;
      LOCKED:  if (loss_hit) state_next = ACQ;
      default: state_next = HUNT;
    endcase
  end

  // Follower byte, run counters, wrap pulse and registered lock flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev      <= 8'd0;
      match_cnt <= 4'd0;
      miss_cnt  <= 4'd0;
      wrap_seen <= 1'b0;
      locked    <= 1'b0;
    end else if (ena) begin
      prev      <= ui_in;
      wrap_seen <= (state == LOCKED) && is_match && (ui_in == 8'd0);
      locked    <= (state_next == LOCKED);
      case (state)
        HUNT: begin
          match_cnt <= 4'd0;
        end
        ACQ: begin
          if (lock_hit) begin
            match_cnt <= 4'd0;
            miss_cnt  <= 4'd0;
          end else if (is_match) begin
            match_cnt <= match_inc;
          end else if (is_miss) begin
            match_cnt <= 4'd0;
          end
        end
        LOCKED: begin
          if (is_match) begin
            miss_cnt <= 4'd0;
          end else if (loss_hit) begin
            match_cnt <= 4'd0;
            miss_cnt  <= 4'd0;
          end else if (is_miss) begin
            miss_cnt <= miss_inc;
          end
        end
        default: begin
          match_cnt <= 4'd0;
          miss_cnt  <= 4'd0;
        end
      endcase
    end
  end

  // Error counter and sticky flag; clear works even with the tile disabled
  // and beats a coincident increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt    <= 16'd0;
      err_sticky <= 1'b0;
    end else if (clr_err) begin
      err_cnt    <= 16'd0;
      err_sticky <= 1'b0;
    end else if (ena && (state == LOCKED) && is_miss) begin
      err_cnt    <= (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'd1;
      err_sticky <= 1'b1;
    end
  end

  // Output pins: error byte mux is combinational so err_sel acts immediately.
  always_comb begin
    uo_out  = err_sel ? err_cnt[15:8] : err_cnt[7:0];
    uio_out = {state, 1'b0, wrap_seen, err_sticky, locked, 2'b00};
    uio_oe  = 8'b1111_1100;
  end

endmodule

// File: tb/tb_tt_um_count_checker.sv
// tb_tt_um_count_checker: directed bench for the counter checker. A default
// instance covers acquisition, wrap, stalls, lock loss and reset; a second
// instance with a long loss threshold drives the error count to saturation.
module tb_tt_um_count_checker;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic       s_rst_n;
  logic       s_ena;
  logic [7:0] s_ui_in;
  logic [7:0] s_uio_in;
  logic [7:0] s_uo_out;
  logic [7:0] s_uio_out;
  logic [7:0] s_uio_oe;

  int checks;
  int errors;

  tt_um_count_checker dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  tt_um_count_checker #(.LOCK_CNT(4), .LOSS_CNT(15)) dut_sat (
    .clk     (clk),
    .rst_n   (s_rst_n),
    .ena     (s_ena),
    .ui_in   (s_ui_in),
    .uio_in  (s_uio_in),
    .uo_out  (s_uo_out),
    .uio_out (s_uio_out),
    .uio_oe  (s_uio_oe)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] expUio(input logic [1:0] st, input logic wrap,
                                         input logic sticky, input logic lck);
    return {8'h00, st, 1'b0, wrap, sticky, lck, 2'b00};
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] ui, input logic en, input logic [7:0] uio);
    ui_in  = ui;
    ena    = en;
    uio_in = uio;
    @(posedge clk);
    #1;
  endtask

  task automatic stepSat(input logic [7:0] ui, input logic [7:0] uio);
    s_ui_in  = ui;
    s_uio_in = uio;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] sprev;
  int         serr;

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    ena      = 1'b0;
    ui_in    = 8'd0;
    uio_in   = 8'd0;
    s_rst_n  = 1'b0;
    s_ena    = 1'b0;
    s_ui_in  = 8'd0;
    s_uio_in = 8'd0;

    // Reset state
    applyStimulus(8'd0, 1'b0, 8'h00);
    applyStimulus(8'd0, 1'b0, 8'h00);
    checkOutput("rst_uo", {8'h00, uo_out}, 16'h0000);
    checkOutput("rst_uio", {8'h00, uio_out}, 16'h0000);
    checkOutput("rst_oe", {8'h00, uio_oe}, 16'h00FC);

    // Acquisition: HUNT->ACQ after edge 1, LOCKED after edge 5
    rst_n   = 1'b1;
    s_rst_n = 1'b1;
    applyStimulus(8'd0, 1'b1, 8'h00);
    checkOutput("acq_edge1", {8'h00, uio_out}, expUio(2'b01, 0, 0, 0));
    for (int v = 1; v <= 3; v++) applyStimulus(8'(v), 1'b1, 8'h00);
    checkOutput("acq_edge4", {8'h00, uio_out}, expUio(2'b01, 0, 0, 0));
    applyStimulus(8'd4, 1'b1, 8'h00);
    checkOutput("lock_edge5", {8'h00, uio_out}, expUio(2'b10, 0, 0, 1));
    checkOutput("lock_uo", {8'h00, uo_out}, 16'h0000);

    // Count up to 253, then wrap through 255->0
    for (int v = 5; v <= 253; v++) applyStimulus(8'(v), 1'b1, 8'h00);
    applyStimulus(8'd254, 1'b1, 8'h00);
    applyStimulus(8'd255, 1'b1, 8'h00);
    checkOutput("pre_wrap", {8'h00, uio_out}, expUio(2'b10, 0, 0, 1));
    applyStimulus(8'd0, 1'b1, 8'h00);
    checkOutput("wrap_pulse", {8'h00, uio_out}, expUio(2'b10, 1, 0, 1));
    applyStimulus(8'd1, 1'b1, 8'h00);
    checkOutput("wrap_end", {8'h00, uio_out}, expUio(2'b10, 0, 0, 1));
    checkOutput("wrap_err", {8'h00, uo_out}, 16'h0000);

    // Stalls and disabled cycles
    for (int v = 2; v <= 10; v++) applyStimulus(8'(v), 1'b1, 8'h00);
    applyStimulus(8'd11, 1'b1, 8'h00);
    applyStimulus(8'd11, 1'b1, 8'h00);
    applyStimulus(8'd11, 1'b1, 8'h00);
    applyStimulus(8'd12, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) applyStimulus(8'd99, 1'b0, 8'h00);
    checkOutput("stall_uio", {8'h00, uio_out}, expUio(2'b10, 0, 0, 1));
    checkOutput("stall_err", {8'h00, uo_out}, 16'h0000);

    // Mismatches while locked, lock loss and relock
    for (int v = 13; v <= 20; v++) applyStimulus(8'(v), 1'b1, 8'h00);
    applyStimulus(8'd50, 1'b1, 8'h00);
    checkOutput("miss1_err", {8'h00, uo_out}, 16'h0001);
    checkOutput("miss1_uio", {8'h00, uio_out}, expUio(2'b10, 0, 1, 1));
    applyStimulus(8'd51, 1'b1, 8'h00);
    applyStimulus(8'd7, 1'b1, 8'h00);
    applyStimulus(8'd3, 1'b1, 8'h00);
    checkOutput("miss3_uio", {8'h00, uio_out}, expUio(2'b10, 0, 1, 1));
    applyStimulus(8'd9, 1'b1, 8'h00);
    checkOutput("loss_err", {8'h00, uo_out}, 16'h0004);
    checkOutput("loss_uio", {8'h00, uio_out}, expUio(2'b01, 0, 1, 0));
    for (int v = 10; v <= 12; v++) applyStimulus(8'(v), 1'b1, 8'h00);
    checkOutput("reacq_uio", {8'h00, uio_out}, expUio(2'b01, 0, 1, 0));
    applyStimulus(8'd13, 1'b1, 8'h00);
    checkOutput("relock_uio", {8'h00, uio_out}, expUio(2'b10, 0, 1, 1));
    checkOutput("relock_err", {8'h00, uo_out}, 16'h0004);
    uio_in = 8'h01;
    #1;
    checkOutput("err_hi_sel", {8'h00, uo_out}, 16'h0000);
    uio_in = 8'h00;
    #1;

    // Clear coincident with a mismatch, then clear while disabled
    applyStimulus(8'd99, 1'b1, 8'h02);
    checkOutput("clr_miss_err", {8'h00, uo_out}, 16'h0000);
    checkOutput("clr_miss_uio", {8'h00, uio_out}, expUio(2'b10, 0, 0, 1));
    applyStimulus(8'd100, 1'b1, 8'h00);
    applyStimulus(8'd200, 1'b1, 8'h00);
    checkOutput("post_clr_err", {8'h00, uo_out}, 16'h0001);
    applyStimulus(8'd201, 1'b0, 8'h02);
    checkOutput("clr_dis_err", {8'h00, uo_out}, 16'h0000);
    checkOutput("clr_dis_uio", {8'h00, uio_out}, expUio(2'b10, 0, 0, 1));

    // Build err_cnt=5 while holding lock, then reset mid-operation
    applyStimulus(8'd201, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'(50 + 40 * i), 1'b1, 8'h00);
      applyStimulus(8'(51 + 40 * i), 1'b1, 8'h00);
    end
    checkOutput("five_err", {8'h00, uo_out}, 16'h0005);
    checkOutput("five_uio", {8'h00, uio_out}, expUio(2'b10, 0, 1, 1));
    rst_n = 1'b0;
    applyStimulus(8'd212, 1'b1, 8'h00);
    checkOutput("midrst_uo", {8'h00, uo_out}, 16'h0000);
    checkOutput("midrst_uio", {8'h00, uio_out}, 16'h0000);
    checkOutput("midrst_oe", {8'h00, uio_oe}, 16'h00FC);
    rst_n = 1'b1;
    for (int v = 0; v <= 4; v++) applyStimulus(8'(v), 1'b1, 8'h00);
    checkOutput("post_rst_lock", {8'h00, uio_out}, expUio(2'b10, 0, 0, 1));

    // Saturation on the long-loss instance
    s_ena = 1'b1;
    for (int v = 0; v <= 4; v++) stepSat(8'(v), 8'h00);
    checkOutput("sat_lock", {8'h00, s_uio_out}, expUio(2'b10, 0, 0, 1));
    sprev = 8'd4;
    serr  = 0;
    for (int g = 0; g < 4682; g++) begin
      for (int k = 0; k < 14; k++) begin
        sprev = sprev + 8'd2;
        stepSat(sprev, 8'h00);
        if (serr < 65535) serr++;
      end
      sprev = sprev + 8'd1;
      stepSat(sprev, 8'h00);
      if (g == 0) checkOutput("sat_first", {8'h00, s_uo_out}, 16'(serr));
    end
    checkOutput("sat_lo", {8'h00, s_uo_out}, 16'(serr & 8'hFF));
    s_uio_in = 8'h01;
    #1;
    checkOutput("sat_hi", {8'h00, s_uo_out}, 16'((serr >> 8) & 8'hFF));
    checkOutput("sat_uio", {8'h00, s_uio_out}, expUio(2'b10, 0, 1, 1));
    sprev = sprev + 8'd2;
    stepSat(sprev, 8'h03);
    checkOutput("sat_clr_hi", {8'h00, s_uo_out}, 16'h0000);
    checkOutput("sat_clr_uio", {8'h00, s_uio_out}, expUio(2'b10, 0, 0, 1));
    sprev = sprev + 8'd2;
    stepSat(sprev, 8'h00);
    checkOutput("sat_after_clr", {8'h00, s_uo_out}, 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
